// File: rtl/simon_pkg.sv
// Shared defaults and FSM state encoding for the SIMON host controller.
package simon_pkg;

    localparam int unsigned SIMON_N     = 64;
    localparam int unsigned SIMON_M     = 4;
    localparam int unsigned SIMON_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        KEY_REQ,
        DATA_REQ,
        BUSY,
        READ_OUT
    } state_e;

endpackage

// File: rtl/simon_out_fifo.sv
// Result buffer between the cipher core and the downstream stream.
// When full, a simultaneous pop frees the slot so a push in the same cycle still succeeds.
module simon_out_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CW'(DEPTH));
        do_pop       = pop_i & ~empty;
        push_ready_o = ~full | do_pop;
        do_push      = push_i & push_ready_o;
        wr_ptr_d     = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d      = count_q + CW'(do_push) - CW'(do_pop);
        valid_o      = ~empty;
        pop_data_o   = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/simon_host_ctrl.sv
// Host-side controller: accepts keys and blocks, sequences the SIMON core handshakes,
// and buffers results for a downstream valid/ready stream.
module simon_host_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned N     = SIMON_N,
    parameter int unsigned M     = SIMON_M,
    parameter int unsigned DEPTH = SIMON_DEPTH
) (
    input  logic           clk,
    input  logic           R,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [M*N-1:0] key_in,
    input  logic           mode_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_block,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_block,
    output logic           newKey,
    output logic           newData,
    output logic           readData,
    output logic [M*N-1:0] key,
    output logic [2*N-1:0] inData,
    output logic           enc_dec,
    input  logic           loadKey,
    input  logic           loadData,
    input  logic           doneData,
    input  logic [2*N-1:0] outData,
    output logic [15:0]    blk_count
);

    state_e         state_q, state_d;
    logic           armed_q;
    logic           key_loaded_q, key_loaded_d;
    logic [M*N-1:0] key_q, key_d;
    logic           enc_dec_q, enc_dec_d;
    logic [2*N-1:0] in_data_q, in_data_d;
    logic           new_key_q, new_key_d;
    logic           new_data_q, new_data_d;
    logic           read_data_q, read_data_d;
    logic [15:0]    blk_count_q, blk_count_d;

    logic           fifo_push, fifo_can_push, fifo_pop;

    always_comb begin
        state_d      = state_q;
        key_loaded_d = key_loaded_q;
        key_d        = key_q;
        enc_dec_d    = enc_dec_q;
        in_data_d    = in_data_q;
        new_key_d    = new_key_q;
        new_data_d   = new_data_q;
        read_data_d  = read_data_q;
        fifo_push    = 1'b0;
        key_ready    = 1'b0;
        in_ready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // armed_q keeps requests off the first edge after reset release;
                // a pending key load masks in_ready so no block handshake is lost.
                key_ready = armed_q;
                in_ready  = armed_q & key_loaded_q & ~key_valid;
                if (armed_q && key_valid) begin
                    key_d     = key_in;
                    enc_dec_d = mode_in;
                    new_key_d = 1'b1;
                    state_d   = KEY_REQ;
                end else if (in_valid && in_ready) begin
                    in_data_d  = in_block;
                    new_data_d = 1'b1;
                    state_d    = DATA_REQ;
                end
            end
            KEY_REQ: begin
                if (loadKey) begin
                    new_key_d    = 1'b0;
                    key_loaded_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            DATA_REQ: begin
                if (loadData) begin
                    new_data_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (doneData && fifo_can_push) begin
                    fifo_push   = 1'b1;
                    read_data_d = 1'b1;
                    state_d     = READ_OUT;
                end
            end
            READ_OUT: begin
                if (!doneData) begin
                    read_data_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = out_valid & out_ready;
        blk_count_d = blk_count_q + {15'd0, fifo_pop};
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            key_loaded_q <= 1'b0;
            key_q        <= '0;
            enc_dec_q    <= 1'b0;
            in_data_q    <= '0;
            new_key_q    <= 1'b0;
            new_data_q   <= 1'b0;
            read_data_q  <= 1'b0;
            blk_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= 1'b1;
            key_loaded_q <= key_loaded_d;
            key_q        <= key_d;
            enc_dec_q    <= enc_dec_d;
            in_data_q    <= in_data_d;
            new_key_q    <= new_key_d;
            new_data_q   <= new_data_d;
            read_data_q  <= read_data_d;
            blk_count_q  <= blk_count_d;
        end
    end

    simon_out_fifo #(
        .WIDTH(2*N),
        .DEPTH(DEPTH)
    ) u_out_fifo (
        .clk         (clk),
        .rst         (R),
        .push_i      (fifo_push),
        .push_data_i (outData),
        .push_ready_o(fifo_can_push),
        .pop_i       (fifo_pop),
        .valid_o     (out_valid),
        .pop_data_o  (out_block)
    );

    assign newKey    = new_key_q;
    assign newData   = new_data_q;
    assign readData  = read_data_q;
    assign key       = key_q;
    assign enc_dec   = enc_dec_q;
    assign inData    = in_data_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_simon_host_ctrl.sv
// Scoreboard bench for simon_host_ctrl with a behavioural SIMON128/256 core model.
module tb_simon_host_ctrl;

    localparam logic [63:0] Z4 = 64'h3DC94C3A046D678B;

    logic           clk = 1'b0;
    logic           R;
    logic           key_valid, key_ready, mode_in;
    logic [255:0]   key_in;
    logic           in_valid, in_ready;
    logic [127:0]   in_block;
    logic           out_valid, out_ready;
    logic [127:0]   out_block;
    logic           newKey, newData, readData, enc_dec;
    logic [255:0]   key;
    logic [127:0]   inData;
    logic           loadKey, loadData, doneData;
    logic [127:0]   outData;
    logic [15:0]    blk_count;

    int             checks = 0;
    int             errors = 0;
    logic [127:0]   sb[$];
    int             exp_cnt = 0;
    int             sent_cnt = 0;
    logic [255:0]   tb_key;
    logic           tb_mode;

    // knobs read by the core model / ready driver
    int             load_cfg = -1;
    int             comp_cfg = -1;
    bit             watch_load = 0;
    int             spur_req = 0;
    bit             rand_ready = 0;
    logic           ready_force = 1'b1;

    simon_host_ctrl #(.N(64), .M(4), .DEPTH(2)) dut (
        .clk(clk), .R(R),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .newKey(newKey), .newData(newData), .readData(readData),
        .key(key), .inData(inData), .enc_dec(enc_dec),
        .loadKey(loadKey), .loadData(loadData), .doneData(doneData), .outData(outData),
        .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic logic [63:0] rf(input logic [63:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [127:0] simon(input logic [255:0] k, input logic enc, input logic [127:0] blk);
        logic [63:0] rk [72];
        logic [63:0] x, y, t;
        for (int i = 0; i < 4; i++) rk[i] = k[64*i +: 64];
        for (int i = 4; i < 72; i++) begin
            t = ror(rk[i-1], 3) ^ rk[i-3];
            t = t ^ ror(t, 1);
            rk[i] = ~rk[i-4] ^ t ^ {63'd0, Z4[(i-4) % 62]} ^ 64'd3;
        end
        x = blk[127:64];
        y = blk[63:0];
        if (enc) begin
            for (int i = 0; i < 72; i++) begin
                t = x; x = y ^ rf(x) ^ rk[i]; y = t;
            end
        end else begin
            for (int i = 71; i >= 0; i--) begin
                t = y; y = x ^ rf(y) ^ rk[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    // Behavioural cipher core, acting mid-cycle on the negative edge.
    typedef enum int {C_IDLE, C_KEYWAIT, C_LOADWAIT, C_COMPUTE, C_DONE} cphase_t;
    cphase_t      cph = C_IDLE;
    int           cdly = 0;
    int           ccomp = 0;
    int           spur_done = 0;
    bit           after_load = 0;
    logic [255:0] core_key = '0;
    logic [127:0] core_res = '0;

    always @(negedge clk) begin
        loadKey  = 1'b0;
        loadData = 1'b0;
        if (R) begin
            cph        = C_IDLE;
            doneData   = 1'b0;
            after_load = 0;
        end else begin
            if (after_load) begin
                chk("newData_drop_after_load", newData, 0);
                after_load = 0;
            end
            case (cph)
                C_IDLE: begin
                    doneData = 1'b0;
                    if (spur_done < spur_req) begin
                        doneData = 1'b1;
                        outData  = {$urandom, $urandom, $urandom, $urandom};
                        spur_done++;
                    end else if (newKey) begin
                        cdly = $urandom_range(0, 3);
                        cph  = C_KEYWAIT;
                    end else if (newData) begin
                        cdly  = (load_cfg < 0) ? int'($urandom_range(0, 3)) : load_cfg;
                        ccomp = (comp_cfg < 0) ? int'($urandom_range(0, 4)) : comp_cfg;
                        cph   = C_LOADWAIT;
                    end
                end
                C_KEYWAIT: begin
                    if (cdly == 0) begin
                        loadKey  = 1'b1;
                        core_key = key;
                        cph      = C_IDLE;
                    end else cdly--;
                end
                C_LOADWAIT: begin
                    if (watch_load) chk("newData_held", newData, 1);
                    if (cdly == 0) begin
                        loadData   = 1'b1;
                        core_res   = simon(core_key, enc_dec, inData);
                        cdly       = ccomp;
                        after_load = watch_load;
                        cph        = C_COMPUTE;
                    end else cdly--;
                end
                C_COMPUTE: begin
                    if (cdly == 0) begin
                        doneData = 1'b1;
                        outData  = core_res;
                        cph      = C_DONE;
                    end else cdly--;
                end
                C_DONE: begin
                    if (readData) begin
                        doneData = 1'b0;
                        cph      = C_IDLE;
                    end
                end
                default: cph = C_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor: samples just before each rising edge.
    always @(negedge clk) begin
        logic [127:0] e;
        #4;
        if (R) begin
            sb.delete();
            exp_cnt = 0;
        end else if (out_valid && out_ready) begin
            chk("blk_count_at_pop", blk_count, exp_cnt);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", out_block);
            end else begin
                e = sb.pop_front();
                chk("out_block", out_block, e);
            end
            exp_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_key_ready(input string name);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #4;
            if (key_ready) begin ok = 1; break; end
        end
        chk(name, ok, 1);
    endtask

    task automatic load_key(input logic [255:0] k, input logic md);
        bit ok = 0;
        @(negedge clk);
        key_valid = 1'b1; key_in = k; mode_in = md;
        for (int i = 0; i < 500; i++) begin
            #4;
            if (key_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("key_accept", ok, 1);
        @(negedge clk);
        key_valid = 1'b0;
        tb_key = k; tb_mode = md;
        wait_key_ready("key_load_done");
        chk("key_out", key, k);
        chk("enc_dec_out", enc_dec, md);
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [127:0] exp);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1'b1; in_block = blk;
        for (int i = 0; i < 3000; i++) begin
            #4;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("in_accept", ok, 1);
        if (ok) begin
            sb.push_back(exp);
            sent_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [127:0] b;
        b = {$urandom, $urandom, $urandom, $urandom};
        send_block(b, simon(tb_key, tb_mode, b));
    endtask

    task automatic wait_drain();
        bit ok = 0;
        rand_ready  = 0;
        ready_force = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #4;
            if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
        @(negedge clk); #4;
        chk("blk_count_after_drain", blk_count, 16'(sent_cnt));
    endtask

    task automatic check_reset_outputs();
        chk("rst_handshake_outs", {key_ready, in_ready, out_valid, newKey, newData, readData, enc_dec}, 0);
        chk("rst_out_block", out_block, 0);
        chk("rst_key", key, 0);
        chk("rst_inData", inData, 0);
        chk("rst_blk_count", blk_count, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        R = 1'b0;
        #4;
        chk("key_ready_before_first_edge", key_ready, 0);
        @(negedge clk); #4;
        chk("key_ready_after_first_edge", key_ready, 1);
    endtask

    initial begin
        logic [255:0] kv;
        logic [127:0] pt, ct;
        kv = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
        pt = 128'h74206E69206D6F6F6D69732061207369;
        ct = 128'h8D2B5579AFC8A3A03BF72A87EFE7B868;

        R = 1'b1; key_valid = 1'b0; key_in = '0; mode_in = 1'b0;
        in_valid = 1'b0; in_block = '0; loadKey = 1'b0; loadData = 1'b0;
        doneData = 1'b0; outData = '0; tb_key = '0; tb_mode = 1'b0;
        cyc(3); #1;
        check_reset_outputs();
        release_reset();

        // no key yet: data must be refused
        @(negedge clk);
        in_valid = 1'b1; in_block = pt;
        cyc(4); #4;
        chk("in_ready_no_key", in_ready, 0);
        chk("newData_no_key", newData, 0);

        // key_valid and in_valid together: key load wins
        @(negedge clk);
        key_valid = 1'b1; key_in = kv; mode_in = 1'b1;
        #4;
        chk("in_ready_while_key_valid", in_ready, 0);
        @(negedge clk);
        key_valid = 1'b0; in_valid = 1'b0;
        #4;
        chk("key_wins_newKey", newKey, 1);
        chk("key_wins_newData", newData, 0);
        tb_key = kv; tb_mode = 1'b1;
        wait_key_ready("first_key_done");
        chk("first_key_out", key, kv);

        // known-answer encrypt then decrypt
        send_block(pt, ct);
        wait_drain();
        load_key(kv, 1'b0);
        send_block(ct, pt);
        wait_drain();

        // spurious doneData while idle
        spur_req = spur_req + 4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #4;
            chk("spurious_readData", readData, 0);
        end
        chk("spurious_no_push", out_valid, 0);
        chk("spurious_blk_count", blk_count, 16'(sent_cnt));

        // randomized traffic with random downstream backpressure
        load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)));
        rand_ready = 1;
        for (int i = 0; i < 12; i++) send_rand();
        wait_drain();

        // slow loadData acknowledgement
        load_cfg   = 7;
        watch_load = 1;
        send_rand();
        wait_drain();
        watch_load = 0;
        load_cfg   = -1;

        // five blocks against a stalled downstream
        rand_ready  = 0;
        ready_force = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
            end
            begin
                cyc(150); #4;
                chk("stall_accepted_blocks", sb.size(), 3);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_readData_low", readData, 0);
                chk("stall_doneData_pending", doneData, 1);
                ready_force = 1'b1;
            end
        join
        wait_drain();

        // reset while the core is busy
        comp_cfg = 40;
        send_rand();
        begin
            bit ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk); #4;
                if (cph == C_COMPUTE) begin ok = 1; break; end
            end
            chk("reach_busy", ok, 1);
        end
        cyc(3);
        R = 1'b1;
        #1;
        check_reset_outputs();
        sent_cnt = 0;
        comp_cfg = -1;
        cyc(3);
        release_reset();
        @(negedge clk);
        in_valid = 1'b1; in_block = pt;
        cyc(30); #4;
        chk("post_reset_no_output", out_valid, 0);
        chk("post_reset_in_ready", in_ready, 0);
        chk("post_reset_newData", newData, 0);
        @(negedge clk);
        in_valid = 1'b0;
        load_key(kv, 1'b1);
        send_block(pt, ct);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simon_host_ctrl.md
SIMON_HOST_CTRL -- requirements
Module: simon_host_ctrl

Interface
REQ-001 Parameters SHALL be: N, 64, word width; M, 4, key words; DEPTH, 2, output buffer entries.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 R  input  1  reset, asynchronous, active-high.
REQ-004 key_valid  input  1 / key_ready  output  1 / key_in  input  M*N / mode_in  input  1: upstream key load with enc_dec mode (1 = encrypt).
REQ-005 in_valid  input  1 / in_ready  output  1 / in_block  input  2N: upstream data block stream.
REQ-006 out_valid  output  1 / out_ready  input  1 / out_block  output  2N: downstream result stream.
REQ-007 newKey, newData, readData  output  1 each; key  output  M*N; inData  output  2N; enc_dec  output  1: cipher-core request side.
REQ-008 loadKey, loadData, doneData  input  1 each; outData  input  2N: cipher-core response side.
REQ-009 blk_count  output  16  number of results delivered downstream since reset.

Function
REQ-010 FSM states SHALL be IDLE, KEY_REQ, DATA_REQ, BUSY, READ_OUT.
REQ-011 IDLE: key_ready=1; key_valid sampled high SHALL latch key_in/mode_in into key/enc_dec and go KEY_REQ; else in_valid with a key loaded SHALL go DATA_REQ.
REQ-012 KEY_REQ: newKey held 1 until loadKey sampled 1; newKey SHALL drop the following cycle, then go IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE with a key loaded; in_valid&in_ready SHALL latch in_block into inData.
REQ-014 DATA_REQ: newData held 1 until loadData sampled 1; newData drops next cycle, go BUSY.
REQ-015 BUSY: on doneData=1 and output buffer not full, SHALL capture outData into buffer, assert readData next cycle, go READ_OUT; if buffer full, SHALL wait with readData=0.
REQ-016 READ_OUT: readData held 1 until doneData sampled 0, then readData=0 and go IDLE.
REQ-017 Exactly one block SHALL be in flight; key and enc_dec SHALL not change while not IDLE.
REQ-018 Output buffer: FIFO of DEPTH entries; out_valid = not empty; pop on out_valid&out_ready; push and pop in same cycle when full SHALL both succeed.
REQ-019 blk_count SHALL increment on each pop, wrap 0xFFFF->0x0000.
REQ-020 key_valid while no key loaded and in_valid both high in IDLE: key load SHALL win.
REQ-021 Data request before any key load SHALL be impossible (in_ready=0).
REQ-022 doneData high with no block in flight SHALL be ignored.

Reset
REQ-023 While R=1 all outputs SHALL be 0, FSM IDLE, FIFO empty, key-loaded flag cleared, blk_count 0.
REQ-024 R asserted mid-transaction SHALL abandon the block; no partial result SHALL be emitted after release.
REQ-025 First request after R release SHALL occur no earlier than the second rising clk edge.

Structure
REQ-026 Package simon_pkg SHALL hold N, M defaults and the FSM state enum.
REQ-027 Output FIFO SHALL be sub-module simon_out_fifo (parameters width, DEPTH).
REQ-028 Implementation SHALL be synchronous except the asynchronous reset; no latches.

Verification
REQ-029 Key 1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100, mode 1, block 74206E69206D6F6F6D69732061207369 against behavioural core -> out_block 8D2B5579AFC8A3A03BF72A87EFE7B868, blk_count=1.
REQ-030 Same key, mode 0, input 8D2B5579AFC8A3A03BF72A87EFE7B868 -> out_block 74206E69206D6F6F6D69732061207369.
REQ-031 Five back-to-back blocks, out_ready=0 -> two results buffered, third held with readData=0 until one pop; all five emitted in order.
REQ-032 Core delays loadData 7 cycles -> newData held exactly until loadData, drops next cycle, one load only.
REQ-033 R pulsed during BUSY -> all outputs 0 immediately, FIFO empty, no result emitted, in_ready=0 until key reloaded.
REQ-034 Spurious doneData in IDLE -> readData stays 0, no push.
